// File: rtl/display_pkg.sv
// Shared types and constants for the result display stage.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

   localparam int DIGITS = 5;
   localparam int WIDTH  = 16;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int CNT_W  = $clog2(WIDTH + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [2:0] ST_DESLIGADO = 3'd0;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [2:0]       estado;
      logic             sr;
      logic [WIDTH-1:0] r;
   } snap_t;

   // Double-dabble correction: each nibble >= 5 gets +3 before the shift.
   function automatic logic [BCD_W-1:0] add3_all(
      input logic [BCD_W-1:0] b
   );
      logic [BCD_W-1:0] res;
      logic [3:0]       nib;
      res = '0;
      for (int i = 0; i < DIGITS; i++) begin
         nib = b[4*i +: 4];
         if (nib >= 4'd5) begin
            nib = nib + 4'd3;
         end
         res[4*i +: 4] = nib;
      end
      return res;
   endfunction

endpackage

// File: rtl/display_resultado_if.sv
// Bundle between the calculator core and the display stage.
// master = calculator side, slave = display stage.
interface display_resultado_if;
   import display_pkg::*;

   logic [WIDTH-1:0] R;
   logic             SR;
   logic [2:0]       Sestado;
   logic [6:0]       HEX0;
   logic [6:0]       HEX1;
   logic [6:0]       HEX2;
   logic [6:0]       HEX3;
   logic [6:0]       HEX4;
   logic [6:0]       HEX5;
   logic             busy;
   logic             done;

   modport master (
      output R, SR, Sestado,
      input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
      input  busy, done
   );

   modport slave (
      input  R, SR, Sestado,
      output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5,
      output busy, done
   );

endinterface

// File: rtl/display_resultado_bcd_7seg.sv
// One BCD digit to active-low 7-segment pattern.
// Codes outside 0..9 and the blank flag both give a dark digit.
module bcd_7seg
   import display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/display_resultado.sv
// Result display: snapshot, double-dabble BCD, registered 7-seg outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module display_resultado
   import display_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   display_resultado_if.slave  bus
);

   state_e                 state_q, state_d;
   snap_t                  snap_q, snap_d;
   logic                   valid_q, valid_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [WIDTH-1:0]       sh_q, sh_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [5:0][6:0]        hex_q, hex_d;
   logic                   done_q, done_d;

   snap_t                  cur_w;
   logic                   off_w;
   logic [DIGITS-1:0]      blank_w;
   logic [DIGITS-1:0][6:0] seg_w;
   logic [6:0]             sign_w;

   assign cur_w = '{estado: bus.Sestado,
                    sr:     bus.SR,
                    r:      bus.R};

   assign off_w = (snap_q.estado == ST_DESLIGADO);

   always_comb begin
      logic lead;
      lead    = 1'b1;
      blank_w = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
         lead = lead & (bcd_q[4*i +: 4] == 4'd0);
         blank_w[i] = off_w | (lead & (i != 0));
`else
         lead = 1'b0;
         blank_w[i] = off_w | lead;
`endif
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_7seg u_seg (
         .digit (bcd_q[4*g +: 4]),
         .blank (blank_w[g]),
         .seg   (seg_w[g])
      );
   end

   // Negative zero is shown as positive.
   assign sign_w = (!off_w && snap_q.sr && snap_q.r != '0)
                 ? SEG_MINUS : SEG_BLANK;

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      valid_d = valid_q;
      bcd_d   = bcd_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!valid_q || cur_w != snap_q) begin
               snap_d  = cur_w;
               valid_d = 1'b1;
               bcd_d   = '0;
               sh_d    = bus.R;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {bcd_d, sh_d} = {add3_all(bcd_q), sh_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            hex_d   = {sign_w, seg_w};
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         snap_q  <= '0;
         valid_q <= 1'b0;
         bcd_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         hex_q   <= {6{SEG_BLANK}};
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         valid_q <= valid_d;
         bcd_q   <= bcd_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         hex_q   <= hex_d;
         done_q  <= done_d;
      end
   end

   assign bus.HEX0 = hex_q[0];
   assign bus.HEX1 = hex_q[1];
   assign bus.HEX2 = hex_q[2];
   assign bus.HEX3 = hex_q[3];
   assign bus.HEX4 = hex_q[4];
   assign bus.HEX5 = hex_q[5];
   assign bus.busy = (state_q != S_IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_display_resultado.sv
// Directed bench for display_resultado.
// Expected leading digits follow LEADING_ZERO_BLANK_EN.
module tb_display_resultado;

   localparam logic [6:0] B  = 7'b1111111;
   localparam logic [6:0] MN = 7'b0111111;
   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D5 = 7'b0010010;
   localparam logic [6:0] D6 = 7'b0000010;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = B;
`else
   localparam logic [6:0] LZ = D0;
`endif

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   n;
   int   seen;

   display_resultado_if bus ();

   display_resultado dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(
      input string       tag,
      input logic [15:0] obs,
      input logic [15:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_hex(
      input string      tag,
      input logic [6:0] e5, e4, e3, e2, e1, e0
   );
      chk({tag, "_hex5"}, 16'(bus.HEX5), 16'(e5));
      chk({tag, "_hex4"}, 16'(bus.HEX4), 16'(e4));
      chk({tag, "_hex3"}, 16'(bus.HEX3), 16'(e3));
      chk({tag, "_hex2"}, 16'(bus.HEX2), 16'(e2));
      chk({tag, "_hex1"}, 16'(bus.HEX1), 16'(e1));
      chk({tag, "_hex0"}, 16'(bus.HEX0), 16'(e0));
   endtask

   task automatic wait_done(input string tag, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.done !== 1'b1 && cyc < 40);
      chk({tag, "_done"}, 16'(bus.done), 16'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.R       = 16'd65025;
      bus.SR      = 1'b0;
      bus.Sestado = 3'd3;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_hex("reset", B, B, B, B, B, B);
      chk("reset_busy", 16'(bus.busy), 16'd0);
      chk("reset_done", 16'(bus.done), 16'd0);

      rst_n = 1'b1;
      @(negedge clk);
      chk("start_busy", 16'(bus.busy), 16'd1);
      wait_done("r65025", n);
      chk("latency", 16'(n + 1), 16'd18);
      chk_hex("r65025", B, D6, D5, D0, D2, D5);
      @(negedge clk);
      chk("pulse_once", 16'(bus.done), 16'd0);

      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(bus.done) + int'(bus.busy);
      end
      chk("stable_idle", 16'(seen), 16'd0);

      bus.R = 16'd12; bus.SR = 1'b1; bus.Sestado = 3'd4;
      wait_done("neg12", n);
      chk_hex("neg12", MN, LZ, LZ, LZ, D1, D2);

      bus.R = 16'd0; bus.SR = 1'b1; bus.Sestado = 3'd2;
      wait_done("negzero", n);
      chk_hex("negzero", B, LZ, LZ, LZ, LZ, D0);

      bus.R = 16'd999; bus.SR = 1'b0; bus.Sestado = 3'd0;
      wait_done("off", n);
      chk_hex("off", B, B, B, B, B, B);

      bus.R = 16'd100; bus.SR = 1'b0; bus.Sestado = 3'd1;
      repeat (5) @(negedge clk);
      bus.R = 16'd200;
      wait_done("r100", n);
      chk_hex("r100", B, LZ, LZ, D1, D0, D0);
      @(negedge clk);
      @(negedge clk);
      chk("restart_busy", 16'(bus.busy), 16'd1);
      chk_hex("hold100", B, LZ, LZ, D1, D0, D0);
      wait_done("r200", n);
      chk_hex("r200", B, LZ, LZ, D2, D0, D0);

      bus.R = 16'd300;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_hex("midrst", B, B, B, B, B, B);
      chk("midrst_busy", 16'(bus.busy), 16'd0);
      rst_n = 1'b1;
      wait_done("r300", n);
      chk_hex("r300", B, LZ, LZ, D3, D0, D0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
